// File: rtl/traffic_phase_ctrl_if.sv
// Sensor/light bundle for traffic_phase_ctrl.
// pedCountdown exists only when TRAFFIC_PED_COUNTDOWN_EN is defined.
interface traffic_phase_ctrl_if;
    logic       pedButton;
    logic [2:0] mainTrafficIn;
    logic [2:0] sideTrafficIn;
    logic       MG, MY, MR;
    logic       SG, SY, SR;
    logic       pedLight;
    logic [2:0] phase;
`ifdef TRAFFIC_PED_COUNTDOWN_EN
    logic [5:0] pedCountdown;
`endif

    // Environment side: drives sensors, observes lights
    modport master (
        output pedButton, mainTrafficIn, sideTrafficIn,
        input  MG, MY, MR, SG, SY, SR, pedLight, phase
`ifdef TRAFFIC_PED_COUNTDOWN_EN
        , pedCountdown
`endif
    );

    // Controller side
    modport slave (
        input  pedButton, mainTrafficIn, sideTrafficIn,
        output MG, MY, MR, SG, SY, SR, pedLight, phase
`ifdef TRAFFIC_PED_COUNTDOWN_EN
        , pedCountdown
`endif
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Main/side intersection phase sequencer with latched pedestrian walk phase.
// Optional walk countdown output enabled by TRAFFIC_PED_COUNTDOWN_EN.
module traffic_phase_ctrl #(
    parameter int unsigned MAIN_MIN      = 20,
    parameter int unsigned SIDE_MIN      = 8,
    parameter int unsigned SIDE_MAX      = 30,
    parameter int unsigned YELLOW_TIME   = 4,
    parameter int unsigned ALLRED_TIME   = 2,
    parameter int unsigned WALK_TIME     = 12,
    parameter int unsigned DEMAND_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    traffic_phase_ctrl_if.slave  bus
);

    localparam int unsigned EW = 6;
    localparam int unsigned SW = 3;
    localparam int unsigned LW = 7;

    localparam logic [EW-1:0] EL_SAT      = '1;
    localparam logic [EW-1:0] MAIN_MIN_M1 = EW'(MAIN_MIN - 1);
    localparam logic [EW-1:0] SIDE_MIN_M1 = EW'(SIDE_MIN - 1);
    localparam logic [EW-1:0] SIDE_MAX_M1 = EW'(SIDE_MAX - 1);
    localparam logic [EW-1:0] YEL_M1      = EW'(YELLOW_TIME - 1);
    localparam logic [EW-1:0] ARED_M1     = EW'(ALLRED_TIME - 1);
    localparam logic [EW-1:0] WALK_M1     = EW'(WALK_TIME - 1);
    localparam logic [2:0]    THRESH      = 3'(DEMAND_THRESH);

    typedef enum logic [SW-1:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALLRED_M    = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALLRED_S    = 3'd5,
        PED_WALK    = 3'd6
    } state_t;

    // Plain vector so the unused encoding 7 is representable and recoverable
    logic [SW-1:0] state_q;
    state_t        state_d;
    logic [EW-1:0] elapsed_q, elapsed_d;
    logic          ped_pending_q, ped_pending_d;
    logic          return_side_q, return_side_d;
    logic [LW-1:0] lights_q, lights_d;

    logic side_demand, main_demand, main_wins;

    assign side_demand = bus.sideTrafficIn >= THRESH;
    assign main_demand = bus.mainTrafficIn >= THRESH;
    assign main_wins   = main_demand && (bus.sideTrafficIn < bus.mainTrafficIn);

    // Light pattern {MG,MY,MR,SG,SY,SR,pedLight} for a state
    function automatic logic [LW-1:0] lights_of(input state_t s);
        logic [LW-1:0] l;
        case (s)
            MAIN_GREEN:  l = 7'b100_001_0;
            MAIN_YELLOW: l = 7'b010_001_0;
            ALLRED_M:    l = 7'b001_001_0;
            SIDE_GREEN:  l = 7'b001_100_0;
            SIDE_YELLOW: l = 7'b001_010_0;
            ALLRED_S:    l = 7'b001_001_0;
            PED_WALK:    l = 7'b001_001_1;
            default:     l = 7'b001_001_0;
        endcase
        return l;
    endfunction

    // Next-state, phase timer and request latch
    always_comb begin
        state_d       = ALLRED_S;
        return_side_d = return_side_q;
        case (state_q)
            MAIN_GREEN: begin
                state_d = MAIN_GREEN;
                if (elapsed_q >= MAIN_MIN_M1 && (side_demand || ped_pending_q))
                    state_d = MAIN_YELLOW;
            end
            MAIN_YELLOW: begin
                state_d = (elapsed_q == YEL_M1) ? ALLRED_M : MAIN_YELLOW;
            end
            ALLRED_M: begin
                state_d = ALLRED_M;
                if (elapsed_q == ARED_M1) begin
                    if (ped_pending_q) begin
                        state_d       = PED_WALK;
                        return_side_d = 1'b1;
                    end else if (side_demand) begin
                        state_d = SIDE_GREEN;
                    end else begin
                        state_d = MAIN_GREEN;
                    end
                end
            end
            SIDE_GREEN: begin
                state_d = SIDE_GREEN;
                if (elapsed_q == SIDE_MAX_M1 ||
                    (elapsed_q >= SIDE_MIN_M1 && (!side_demand || ped_pending_q || main_wins)))
                    state_d = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                state_d = (elapsed_q == YEL_M1) ? ALLRED_S : SIDE_YELLOW;
            end
            ALLRED_S: begin
                state_d = ALLRED_S;
                if (elapsed_q == ARED_M1) begin
                    if (ped_pending_q) begin
                        state_d       = PED_WALK;
                        return_side_d = 1'b0;
                    end else begin
                        state_d = MAIN_GREEN;
                    end
                end
            end
            PED_WALK: begin
                state_d = PED_WALK;
                if (elapsed_q == WALK_M1)
                    state_d = (return_side_q && side_demand) ? SIDE_GREEN : MAIN_GREEN;
            end
            default: state_d = ALLRED_S;
        endcase

        if (state_q != SW'(state_d))
            elapsed_d = '0;
        else if (elapsed_q == EL_SAT)
            elapsed_d = elapsed_q;
        else
            elapsed_d = elapsed_q + EW'(1);

        // Entering the walk clears the latch even if the button is held
        ped_pending_d = ped_pending_q;
        if (state_d == PED_WALK && state_q != SW'(PED_WALK))
            ped_pending_d = 1'b0;
        else if (bus.pedButton && state_q != SW'(PED_WALK))
            ped_pending_d = 1'b1;

        lights_d = lights_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SW'(MAIN_GREEN);
            elapsed_q     <= '0;
            ped_pending_q <= 1'b0;
            return_side_q <= 1'b0;
            lights_q      <= lights_of(MAIN_GREEN);
        end else begin
            state_q       <= SW'(state_d);
            elapsed_q     <= elapsed_d;
            ped_pending_q <= ped_pending_d;
            return_side_q <= return_side_d;
            lights_q      <= lights_d;
        end
    end

    assign {bus.MG, bus.MY, bus.MR, bus.SG, bus.SY, bus.SR, bus.pedLight} = lights_q;
    assign bus.phase = state_q;

`ifdef TRAFFIC_PED_COUNTDOWN_EN
    logic [EW-1:0] cd_q, cd_d;

    always_comb begin
        cd_d = '0;
        if (state_d == PED_WALK)
            cd_d = WALK_M1 - elapsed_d;
    end

    always_ff @(posedge clk) begin
        if (reset) cd_q <= '0;
        else       cd_q <= cd_d;
    end

    assign bus.pedCountdown = cd_q;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: directed scenarios push per-cycle
// expected phases; a negedge monitor pops and compares against the outputs.
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    traffic_phase_ctrl_if bus();

    traffic_phase_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [2:0] P_MG  = 3'd0;
    localparam logic [2:0] P_MY  = 3'd1;
    localparam logic [2:0] P_ARM = 3'd2;
    localparam logic [2:0] P_SG  = 3'd3;
    localparam logic [2:0] P_SY  = 3'd4;
    localparam logic [2:0] P_ARS = 3'd5;
    localparam logic [2:0] P_PED = 3'd6;

    typedef struct {
        logic       care;
        logic [2:0] ph;
        logic [5:0] cd;
        int         idx;
    } exp_t;

    exp_t  q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string scen     = "init";

    // Expected {MG,MY,MR,SG,SY,SR,pedLight} for each legal phase
    function automatic logic [6:0] lights_of(input logic [2:0] ph);
        case (ph)
            P_MG:    return 7'b1000010;
            P_MY:    return 7'b0100010;
            P_ARM:   return 7'b0010010;
            P_SG:    return 7'b0011000;
            P_SY:    return 7'b0010100;
            P_ARS:   return 7'b0010010;
            P_PED:   return 7'b0010011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic seg(input logic [2:0] ph, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.care = 1'b1;
            e.ph   = ph;
            e.cd   = (ph == P_PED) ? 6'(11 - i) : 6'd0;
            e.idx  = q.size();
            q.push_back(e);
        end
    endtask

    task automatic skip_one();
        exp_t e;
        e.care = 1'b0;
        e.ph   = 3'd0;
        e.cd   = 6'd0;
        e.idx  = q.size();
        q.push_back(e);
    endtask

    // Monitor: one comparison per expected cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [15:0] got, want;
            e = q.pop_front();
            if (e.care) begin
                got  = {bus.phase, bus.MG, bus.MY, bus.MR, bus.SG, bus.SY, bus.SR, bus.pedLight, 6'd0};
                want = {e.ph, lights_of(e.ph), 6'd0};
`ifdef TRAFFIC_PED_COUNTDOWN_EN
                got[5:0]  = bus.pedCountdown;
                want[5:0] = e.cd;
`endif
                n_checks++;
                if (got === want)
                    n_pass++;
                else
                    $display("FAIL %s cycle %0d: got phase/lights/cd=%h want %h",
                             scen, e.idx, got, want);
            end
        end
    end

    // Reset for 3 cycles with given sensors; returns 1 time unit after the last reset edge
    task automatic do_reset(input logic [2:0] side, input logic [2:0] main_t);
        @(posedge clk);
        #1;
        reset             = 1'b1;
        bus.pedButton     = 1'b0;
        bus.sideTrafficIn = side;
        bus.mainTrafficIn = main_t;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL %s drain: %0d expected cycles left, want 0", scen, q.size());
            q.delete();
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.pedButton     = 1'b0;
        bus.sideTrafficIn = 3'd0;
        bus.mainTrafficIn = 3'd0;

        scen = "idle";
        do_reset(3'd0, 3'd0);
        seg(P_MG, 100);
        drain();

        scen = "main_only";
        do_reset(3'd0, 3'd5);
        seg(P_MG, 40);
        drain();

        scen = "side_max";
        do_reset(3'd1, 3'd0);
        seg(P_MG, 20); seg(P_MY, 4); seg(P_ARM, 2);
        seg(P_SG, 30); seg(P_SY, 4); seg(P_ARS, 2); seg(P_MG, 5);
        drain();

        scen = "side_drop";
        do_reset(3'd1, 3'd0);
        seg(P_MG, 20); seg(P_MY, 4); seg(P_ARM, 2);
        seg(P_SG, 8); seg(P_SY, 4); seg(P_ARS, 2); seg(P_MG, 10);
        step(29);
        bus.sideTrafficIn = 3'd0;
        drain();

        scen = "main_wins";
        do_reset(3'd1, 3'd3);
        seg(P_MG, 20); seg(P_MY, 4); seg(P_ARM, 2);
        seg(P_SG, 8); seg(P_SY, 4); seg(P_ARS, 2); seg(P_MG, 5);
        drain();

        scen = "ped_idle";
        do_reset(3'd0, 3'd0);
        seg(P_MG, 20); seg(P_MY, 4); seg(P_ARM, 2);
        seg(P_PED, 12); seg(P_MG, 40);
        step(5);  bus.pedButton = 1'b1;
        step(1);  bus.pedButton = 1'b0;
        step(24); bus.pedButton = 1'b1;
        step(1);  bus.pedButton = 1'b0;
        drain();

        scen = "ped_return_side";
        do_reset(3'd1, 3'd0);
        seg(P_MG, 20); seg(P_MY, 4); seg(P_ARM, 2);
        seg(P_PED, 12); seg(P_SG, 5);
        step(5); bus.pedButton = 1'b1;
        step(1); bus.pedButton = 1'b0;
        drain();

        scen = "ped_in_side";
        do_reset(3'd1, 3'd0);
        seg(P_MG, 20); seg(P_MY, 4); seg(P_ARM, 2);
        seg(P_SG, 8); seg(P_SY, 4); seg(P_ARS, 2);
        seg(P_PED, 12); seg(P_MG, 10);
        step(28); bus.pedButton = 1'b1;
        step(1);  bus.pedButton = 1'b0;
        drain();

        // Reset inside yellow must also drop a latched pedestrian request
        scen = "reset_mid_yellow";
        do_reset(3'd1, 3'd0);
        seg(P_MG, 20); seg(P_MY, 2); seg(P_MG, 30);
        step(10); bus.pedButton = 1'b1;
        step(1);  bus.pedButton = 1'b0;
        step(10);
        reset             = 1'b1;
        bus.sideTrafficIn = 3'd0;
        step(1);
        reset = 1'b0;
        drain();

        scen = "illegal_state";
        do_reset(3'd0, 3'd0);
        seg(P_MG, 5); skip_one(); seg(P_ARS, 2); seg(P_MG, 10);
        step(5);
        dut.state_q = 3'd7;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
